// File: rtl/sub_modp_if.sv
// -----------------------------------------------------------------------------
// sub_modp_if : operand/result bundle for the Curve25519 modular subtractor.
//
// Signals
//   in_valid  : operands x, y are valid this cycle          (master -> slave)
//   x, y      : minuend / subtrahend, any value 0..2^N-1     (master -> slave)
//   out_valid : diff holds a new result this cycle           (slave -> master)
//   diff      : (x - y) mod p, canonical 0..p-1              (slave -> master)
//
// Modports
//   master : the block issuing operations (drives the operands)
//   slave  : the subtractor (drives the result)
// -----------------------------------------------------------------------------
interface sub_modp_if #(
    parameter int N = 255
);
    logic         in_valid;
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         out_valid;
    logic [N-1:0] diff;

    modport master (
        output in_valid, x, y,
        input  out_valid, diff
    );

    modport slave (
        input  in_valid, x, y,
        output out_valid, diff
    );
endinterface

// File: rtl/sub_modp.sv
// -----------------------------------------------------------------------------
// sub_modp : registered modular subtractor over the Curve25519 field,
//            p = 2^255 - 19.  diff = (x - y) mod p, always canonical.
//
// Operands may be non-canonical (p..2^255-1); each is folded once into
// 0..p-1 before the subtraction, which is enough because 2^255-1 < 2p.
//
// Ports
//   clk  : system clock, rising edge
//   rst  : synchronous, active-high reset (clears valid and result)
//   bus  : sub_modp_if.slave  (in_valid, x, y  ->  out_valid, diff)
//
// Configuration
//   SUB_MODP_PIPE_EN undefined : 1-cycle latency (reduce+subtract+correct)
//   SUB_MODP_PIPE_EN defined   : 2-cycle latency, register after reduction
//   Results are identical in both builds; throughput is one per clock.
//
// Parameter N is fixed at 255 because p is tied to the operand width.
// -----------------------------------------------------------------------------
module sub_modp #(
    parameter int N = 255
) (
    input  logic      clk,
    input  logic      rst,
    sub_modp_if.slave bus
);

    // p = (2^N - 1) - 18 = 2^N - 19
    localparam logic [N-1:0] P = {N{1'b1}} - N'(18);

    // Fold an operand from 0..2^N-1 into 0..p-1 with one conditional subtract.
    function automatic logic [N-1:0] reduce_op(input logic [N-1:0] v);
        reduce_op = (v >= P) ? (v - P) : v;
    endfunction

    // Subtract two canonical values; the extra top bit carries the borrow so
    // nothing is truncated before the sign is known. Adding p back wraps
    // modulo 2^N, which lands exactly in 0..p-1.
    function automatic logic [N-1:0] sub_fold(input logic [N-1:0] a,
                                              input logic [N-1:0] b);
        logic [N:0] t;
        t        = {1'b0, a} - {1'b0, b};
        sub_fold = t[N] ? (t[N-1:0] + P) : t[N-1:0];
    endfunction

    logic         vld_p1_d, vld_p1_q;
    logic [N-1:0] diff_p1_d, diff_p1_q;

`ifdef SUB_MODP_PIPE_EN
    logic         vld_p0_d, vld_p0_q;
    logic [N-1:0] xr_p0_d, xr_p0_q;
    logic [N-1:0] yr_p0_d, yr_p0_q;

    // Stage 0: operand reduction
    always_comb begin
        vld_p0_d = bus.in_valid;
        xr_p0_d  = xr_p0_q;
        yr_p0_d  = yr_p0_q;
        if (bus.in_valid) begin
            xr_p0_d = reduce_op(bus.x);
            yr_p0_d = reduce_op(bus.y);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0_q <= 1'b0;
            xr_p0_q  <= '0;
            yr_p0_q  <= '0;
        end else begin
            vld_p0_q <= vld_p0_d;
            xr_p0_q  <= xr_p0_d;
            yr_p0_q  <= yr_p0_d;
        end
    end

    // Stage 1: subtraction and correction into the output register
    always_comb begin
        vld_p1_d  = vld_p0_q;
        diff_p1_d = diff_p1_q;
        if (vld_p0_q) begin
            diff_p1_d = sub_fold(xr_p0_q, yr_p0_q);
        end
    end
`else
    // Stage 1: reduction, subtraction and correction in one cycle
    always_comb begin
        vld_p1_d  = bus.in_valid;
        diff_p1_d = diff_p1_q;
        if (bus.in_valid) begin
            diff_p1_d = sub_fold(reduce_op(bus.x), reduce_op(bus.y));
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q  <= 1'b0;
            diff_p1_q <= '0;
        end else begin
            vld_p1_q  <= vld_p1_d;
            diff_p1_q <= diff_p1_d;
        end
    end

    assign bus.out_valid = vld_p1_q;
    assign bus.diff      = diff_p1_q;

endmodule

// File: tb/tb_sub_modp.sv
// -----------------------------------------------------------------------------
// tb_sub_modp : self-checking bench for sub_modp.
//   Directed vector table, back-to-back stream, reset sequence and a random
//   regression against an independent mod-p reference model.
//   Latency follows SUB_MODP_PIPE_EN (1 or 2 cycles).
// -----------------------------------------------------------------------------
module tb_sub_modp;

    localparam int N = 255;
`ifdef SUB_MODP_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    localparam logic [N-1:0] P    = {N{1'b1}} - N'(18);
    localparam logic [N-1:0] MAXV = {N{1'b1}};

    logic clk = 1'b0;
    logic rst = 1'b1;

    sub_modp_if #(.N(N)) bus ();

    sub_modp #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected-output pipeline: entries pushed when inputs are driven,
    // popped LAT cycles later when the result should be visible.
    logic         q_v[$];
    logic [N-1:0] q_e[$];
    logic [N-1:0] last_diff = '0;

    typedef struct {
        logic [N-1:0] x;
        logic [N-1:0] y;
        logic [N-1:0] exp;
    } vec_t;

    task automatic cmp1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b want %0b", name, act, exp);
        end
    endtask

    task automatic cmpn(input string name, input logic [N-1:0] act,
                        input logic [N-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Independent model: ((x mod p) - (y mod p) + p) mod p in wider arithmetic.
    function automatic logic [N-1:0] ref_model(input logic [N-1:0] a,
                                               input logic [N-1:0] b);
        logic [N+1:0] pp, am, bm, r;
        pp = {2'b00, P};
        am = {2'b00, a} % pp;
        bm = {2'b00, b} % pp;
        r  = (am + pp - bm) % pp;
        return r[N-1:0];
    endfunction

    function automatic logic [N-1:0] rand_op();
        logic [255:0] r;
        int sel;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
        sel = $urandom_range(0, 7);
        if (sel < 2)       return P + N'($urandom_range(0, 18));
        else if (sel == 2) return N'($urandom_range(0, 40));
        else if (sel == 3) return P - N'($urandom_range(1, 40));
        else               return r[N-1:0];
    endfunction

    // One clock: check the result due now, then drive the next inputs.
    task automatic cyc(input string name, input logic v, input logic [N-1:0] xx,
                       input logic [N-1:0] yy, input logic [N-1:0] ee);
        logic         ev;
        logic [N-1:0] e2;
        @(negedge clk);
        if (q_v.size() >= LAT) begin
            ev = q_v.pop_front();
            e2 = q_e.pop_front();
            if (ev) last_diff = e2;
            cmp1({name, ".out_valid"}, bus.out_valid, ev);
            cmpn({name, ".diff"}, bus.diff, last_diff);
        end
        bus.in_valid = v;
        bus.x        = xx;
        bus.y        = yy;
        q_v.push_back(v);
        q_e.push_back(ee);
    endtask

    task automatic flush();
        for (int k = 0; k < LAT + 1; k++) cyc("flush", 1'b0, '0, '0, '0);
    endtask

    vec_t vecs[$];

    initial begin
        vecs.push_back('{x: '0,            y: '0,      exp: '0});
        vecs.push_back('{x: '0,            y: N'(1),   exp: P - N'(1)});
        vecs.push_back('{x: '0,            y: N'(2),   exp: P - N'(2)});
        vecs.push_back('{x: '0,            y: P,       exp: '0});
        vecs.push_back('{x: P + N'(5),     y: N'(3),   exp: N'(2)});
        vecs.push_back('{x: MAXV,          y: '0,      exp: N'(18)});
        vecs.push_back('{x: P - N'(1),     y: '0,      exp: P - N'(1)});
        vecs.push_back('{x: N'(12345),     y: N'(12345), exp: '0});
        vecs.push_back('{x: '0,            y: MAXV,    exp: P - N'(18)});
        vecs.push_back('{x: N'(100),       y: P + N'(1), exp: N'(99)});
        vecs.push_back('{x: MAXV,          y: MAXV,    exp: '0});
        vecs.push_back('{x: N'(3),         y: N'(10),  exp: P - N'(7)});

        // Reset: rst held 2 cycles with a valid operation presented.
        bus.in_valid = 1'b1;
        bus.x        = N'(5);
        bus.y        = N'(3);
        rst          = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            cmp1("rst.out_valid", bus.out_valid, 1'b0);
            cmpn("rst.diff", bus.diff, '0);
        end
        bus.in_valid = 1'b0;
        rst          = 1'b0;
        for (int k = 0; k < LAT + 1; k++) begin
            @(negedge clk);
            cmp1("post_rst.out_valid", bus.out_valid, 1'b0);
            cmpn("post_rst.diff", bus.diff, '0);
        end

        // Directed table, each vector followed by an idle cycle.
        for (int i = 0; i < vecs.size(); i++) begin
            cyc($sformatf("vec%0d", i), 1'b1, vecs[i].x, vecs[i].y, vecs[i].exp);
            cyc($sformatf("vec%0d_idle", i), 1'b0, '0, '0, '0);
        end
        flush();

        // Back-to-back stream.
        cyc("b2b0", 1'b1, N'(10),    N'(3),     N'(7));
        cyc("b2b1", 1'b1, N'(3),     N'(10),    P - N'(7));
        cyc("b2b2", 1'b1, P - N'(1), P - N'(1), '0);
        flush();

        // Reset in the middle of a stream discards in-flight results.
        cyc("pre_rst", 1'b1, N'(9), N'(4), N'(5));
        @(negedge clk);
        bus.in_valid = 1'b1;
        rst          = 1'b1;
        @(negedge clk);
        cmp1("mid_rst.out_valid", bus.out_valid, 1'b0);
        cmpn("mid_rst.diff", bus.diff, '0);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        q_v.delete();
        q_e.delete();
        last_diff = '0;
        for (int k = 0; k < LAT + 1; k++) begin
            @(negedge clk);
            cmp1("mid_rst_rel.out_valid", bus.out_valid, 1'b0);
            cmpn("mid_rst_rel.diff", bus.diff, '0);
        end

        // Random regression.
        for (int i = 0; i < 10000; i++) begin
            logic [N-1:0] a, b;
            logic v;
            a = rand_op();
            b = rand_op();
            v = ($urandom_range(0, 7) != 0);
            cyc("rand", v, a, b, ref_model(a, b));
        end
        flush();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
